// File: rtl/press_arbiter.sv
// Three-channel push-button press arbiter.
// Rising edges on the synchronized button levels are latched as pending
// events. A small IDLE/OFFER/HOLD FSM offers them one at a time to a
// valid/ready consumer in round-robin order. After each grant it enforces a
// lockout of HOLDOFF cycles. A press that arrives while its channel is
// already pending is recorded in a sticky dropped flag.
module press_arbiter #(
    parameter int HOLDOFF = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] btn,
    output logic       req_valid,
    output logic [1:0] req_id,
    input  logic       req_ready,
    output logic [2:0] pending,
    output logic [2:0] dropped,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // The counter is loaded with HOLDOFF-1 at the grant, so HOLD spans
    // exactly HOLDOFF cycles.
    localparam logic [7:0] HOLD_LOAD = 8'(HOLDOFF - 1);

    state_t     state_r;
    logic [2:0] prev_r;
    logic [7:0] cnt_r;
    logic [1:0] last_r;
    logic [2:0] pending_r;
    logic [2:0] dropped_r;
    logic [1:0] req_id_r;
    logic       req_valid_r;
    logic       busy_r;

    logic [2:0] rise_s;
    logic       grant_s;
    logic [2:0] grant_mask_s;
    logic [2:0] pending_next_s;
    logic [2:0] dropped_next_s;

    // Round-robin choice: search last+1, last+2, last+3 (mod 3) and take the
    // first pending channel. Only called when at least one bit is set.
    function automatic logic [1:0] rr_pick(input logic [2:0] pend,
                                           input logic [1:0] last);
        logic [1:0] first;
        logic [1:0] second;
        logic [1:0] third;
        case (last)
            2'd0: begin
                first  = 2'd1;
                second = 2'd2;
                third  = 2'd0;
            end
            2'd1: begin
                first  = 2'd2;
                second = 2'd0;
                third  = 2'd1;
            end
            default: begin
                first  = 2'd0;
                second = 2'd1;
                third  = 2'd2;
            end
        endcase
        if (pend[first]) begin
            rr_pick = first;
        end else if (pend[second]) begin
            rr_pick = second;
        end else begin
            rr_pick = third;
        end
    endfunction

    // Edge detection, grant decode and next values of the event bookkeeping.
    // A new rise wins over a simultaneous grant of the same channel.
    always_comb begin
        rise_s       = btn & ~prev_r;
        grant_s      = 1'b0;
        grant_mask_s = 3'b000;
        if ((state_r == OFFER) && req_ready) begin
            grant_s = 1'b1;
            case (req_id_r)
                2'd0:    grant_mask_s = 3'b001;
                2'd1:    grant_mask_s = 3'b010;
                default: grant_mask_s = 3'b100;
            endcase
        end else begin
            grant_s      = 1'b0;
            grant_mask_s = 3'b000;
        end
        pending_next_s = (pending_r & ~grant_mask_s) | rise_s;
        dropped_next_s = dropped_r | (rise_s & pending_r & ~grant_mask_s);
    end

    // All state and every output register; reset overrides everything.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            prev_r      <= 3'b000;
            cnt_r       <= 8'd0;
            last_r      <= 2'd2;
            pending_r   <= 3'b000;
            dropped_r   <= 3'b000;
            req_id_r    <= 2'd0;
            req_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            prev_r    <= btn;
            pending_r <= pending_next_s;
            dropped_r <= dropped_next_s;
            case (state_r)
                IDLE: begin
                    if (pending_r != 3'b000) begin
                        state_r     <= OFFER;
                        req_id_r    <= rr_pick(pending_r, last_r);
                        req_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= IDLE;
                        req_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                    end
                end
                OFFER: begin
                    if (grant_s) begin
                        state_r     <= HOLD;
                        last_r      <= req_id_r;
                        cnt_r       <= HOLD_LOAD;
                        req_valid_r <= 1'b0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= OFFER;
                        req_valid_r <= 1'b1;
                        busy_r      <= 1'b1;
                    end
                end
                HOLD: begin
                    req_valid_r <= 1'b0;
                    if (cnt_r == 8'd0) begin
                        state_r <= IDLE;
                        busy_r  <= 1'b0;
                    end else begin
                        cnt_r  <= cnt_r - 8'd1;
                        busy_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    req_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid = req_valid_r;
    assign req_id    = req_id_r;
    assign pending   = pending_r;
    assign dropped   = dropped_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_press_arbiter.sv
// Self-checking bench for press_arbiter: a per-cycle vector table for the
// single-press and backpressure/drop scenarios, hand-written sequences for
// the multi-cycle corners, and a queue of expected grant ids that is
// checked at every observed handshake.
module tb_press_arbiter;
    localparam int HOLDOFF = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] btn;
    logic       req_valid;
    logic [1:0] req_id;
    logic       req_ready;
    logic [2:0] pending;
    logic [2:0] dropped;
    logic       busy;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;
    int grants = 0;
    logic [1:0] exp_q[$];
    int         grant_cyc[$];

    always #5 clk = ~clk;

    press_arbiter #(.HOLDOFF(HOLDOFF)) dut (
        .clk       (clk),
        .reset     (reset),
        .btn       (btn),
        .req_valid (req_valid),
        .req_id    (req_id),
        .req_ready (req_ready),
        .pending   (pending),
        .dropped   (dropped),
        .busy      (busy)
    );

    typedef struct {
        logic [2:0] b;
        logic       r;
        logic       v;
        logic [1:0] id;
        logic [2:0] p;
        logic [2:0] d;
        logic       bz;
    } vec_t;

    vec_t tbl[20];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Drive one cycle of inputs, score a handshake if one occurs at this
    // edge, then advance to 1 time unit after the edge.
    task automatic step(input logic [2:0] b, input logic r, input logic rst);
        logic [1:0] e;
        btn       = b;
        req_ready = r;
        reset     = rst;
        if (!rst && (req_valid === 1'b1) && r) begin
            checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL grant_order: got id %0d, expected no grant", req_id);
            end else begin
                e = exp_q.pop_front();
                if (req_id === e) passed++;
                else $display("FAIL grant_order: got id %0d, expected id %0d", req_id, e);
            end
            grant_cyc.push_back(cyc);
            grants++;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_grants(input int target, input int budget,
                               input logic [2:0] b, input logic r);
        int n;
        n = 0;
        while ((grants < target) && (n < budget)) begin
            step(b, r, 1'b0);
            n++;
        end
        if (grants < target) begin
            checks++;
            $display("FAIL grant_timeout: got %0d grants, expected %0d", grants, target);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 1'b1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int g0;
        int p0;
        btn       = 3'b000;
        req_ready = 1'b0;
        reset     = 1'b1;

        tbl = '{
            // single press, ready held high
            '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0},
            '{3'b001, 1'b1, 1'b0, 2'd0, 3'b001, 3'b000, 1'b0},
            '{3'b001, 1'b1, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1},
            '{3'b001, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1},
            '{3'b001, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1},
            '{3'b001, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1},
            '{3'b001, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b1},
            '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b000, 1'b0},
            // backpressure with a second press on ch0 while pending
            '{3'b001, 1'b0, 1'b0, 2'd0, 3'b001, 3'b000, 1'b0},
            '{3'b001, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1},
            '{3'b000, 1'b0, 1'b1, 2'd0, 3'b001, 3'b000, 1'b1},
            '{3'b001, 1'b0, 1'b1, 2'd0, 3'b001, 3'b001, 1'b1},
            '{3'b001, 1'b0, 1'b1, 2'd0, 3'b001, 3'b001, 1'b1},
            '{3'b000, 1'b1, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 1'b1},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 1'b0},
            '{3'b000, 1'b0, 1'b0, 2'd0, 3'b000, 3'b001, 1'b0}
        };

        // reset state
        step(3'b000, 1'b0, 1'b1);
        step(3'b000, 1'b0, 1'b1);
        check("reset_state", {req_valid, req_id, pending, dropped, busy}, 10'd0);

        // vector table: one grant of ch0 in each of the two scenarios
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].b, tbl[i].r, 1'b0);
            check($sformatf("vec%0d", i), {req_valid, req_id, pending, dropped, busy},
                  {tbl[i].v, tbl[i].id, tbl[i].p, tbl[i].d, tbl[i].bz});
        end

        // reset clears the sticky dropped flag and restores ch0 priority
        step(3'b000, 1'b0, 1'b1);
        check("reset_clears_dropped", {req_valid, pending, dropped, busy}, 8'd0);

        // simultaneous press: grants 0,1,2 spaced HOLDOFF+2 apart
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        g0 = grants;
        p0 = cyc;
        step(3'b111, 1'b1, 1'b0);
        check("simul_pending", {req_valid, pending}, 4'b0111);
        wait_grants(g0 + 3, 40, 3'b000, 1'b1);
        if (grants >= g0 + 3) begin
            check("simul_latency", grant_cyc[g0] - p0, 2);
            check("simul_space1", grant_cyc[g0 + 1] - grant_cyc[g0], HOLDOFF + 2);
            check("simul_space2", grant_cyc[g0 + 2] - grant_cyc[g0 + 1], HOLDOFF + 2);
        end
        check("simul_pending_end", pending, 3'b000);
        idle(6);

        // round robin: after ch1 granted with 101 pending, serve 2 then 0
        exp_q.push_back(2'd1);
        exp_q.push_back(2'd2);
        exp_q.push_back(2'd0);
        g0 = grants;
        step(3'b010, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b101, 1'b1, 1'b0);
        check("rr_pending_in_hold", {req_valid, pending, busy}, 5'b0_101_1);
        wait_grants(g0 + 3, 40, 3'b000, 1'b1);
        if (grants >= g0 + 3) begin
            check("rr_space", grant_cyc[g0 + 1] - grant_cyc[g0], HOLDOFF + 2);
        end
        idle(6);

        // reset in HOLD with 110 pending wipes everything
        exp_q.push_back(2'd0);
        step(3'b001, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b110, 1'b1, 1'b0);
        check("hold_pending_110", {pending, busy}, 4'b110_1);
        step(3'b000, 1'b1, 1'b1);
        check("reset_mid_hold", {req_valid, req_id, pending, dropped, busy}, 10'd0);
        g0 = grants;
        idle(15);
        check("no_grant_after_reset", grants, g0);
        exp_q.push_back(2'd2);
        step(3'b100, 1'b1, 1'b0);
        wait_grants(g0 + 1, 20, 3'b000, 1'b1);
        idle(6);

        // held button gives one event per 0->1 transition
        exp_q.push_back(2'd1);
        g0 = grants;
        for (int i = 0; i < 50; i++) step(3'b010, 1'b1, 1'b0);
        check("held_one_grant", grants, g0 + 1);
        step(3'b000, 1'b1, 1'b0);
        exp_q.push_back(2'd1);
        wait_grants(g0 + 2, 20, 3'b010, 1'b1);
        for (int i = 0; i < 10; i++) step(3'b010, 1'b1, 1'b0);
        check("held_second_grant", grants, g0 + 2);
        idle(6);

        // rise coinciding with grant of the same channel: set wins, no drop
        exp_q.push_back(2'd0);
        exp_q.push_back(2'd0);
        g0 = grants;
        step(3'b001, 1'b1, 1'b0);
        step(3'b000, 1'b1, 1'b0);
        step(3'b001, 1'b1, 1'b0);
        check("setwins_pending", {pending, dropped}, 6'b001_000);
        wait_grants(g0 + 2, 20, 3'b000, 1'b1);
        check("setwins_pending_end", {pending, dropped}, 6'b000_000);
        idle(6);

        // button already high when reset deasserts counts as one press
        step(3'b100, 1'b0, 1'b1);
        step(3'b100, 1'b0, 1'b1);
        exp_q.push_back(2'd2);
        g0 = grants;
        step(3'b100, 1'b1, 1'b0);
        check("press_through_reset", pending, 3'b100);
        wait_grants(g0 + 1, 20, 3'b100, 1'b1);
        for (int i = 0; i < 20; i++) step(3'b100, 1'b1, 1'b0);
        check("press_through_reset_once", grants, g0 + 1);

        check("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/press_arbiter.md
PRESS_ARBITER -- requirements
Module: press_arbiter

Interface
REQ-001 Parameter: HOLDOFF, 4, number of lockout cycles after each grant; legal range 1..255, held in an 8-bit counter.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-004 btn  input  3  already-synchronized button levels, one bit per channel 0..2.
REQ-005 req_valid  output  1  a press event is offered to the consumer.
REQ-006 req_id  output  2  channel of the offered event, 0..2; value 3 is never driven.
REQ-007 req_ready  input  1  consumer accepts the offered event this cycle.
REQ-008 pending  output  3  per-channel press events latched and not yet granted.
REQ-009 dropped  output  3  sticky per-channel flag: a press was lost because that channel was already pending.
REQ-010 busy  output  1  high whenever the FSM is not in IDLE.
REQ-011 All outputs SHALL be driven directly from registers, with no combinational path from any input.

Function
REQ-012 Edge detect SHALL use a 3-bit prev register that captures btn every cycle; rise = btn AND NOT prev.
REQ-013 A rise on channel i SHALL set pending[i] at the same edge.
REQ-014 If rise[i] occurs while pending[i] is already 1 and that event is not being granted at this edge, dropped[i] SHALL set. pending[i] SHALL stay 1.
REQ-015 The FSM SHALL have states IDLE, OFFER and HOLD.
REQ-016 IDLE, pending != 0: go to OFFER and latch req_id using round-robin order last+1, last+2, last+3 (mod 3); otherwise stay in IDLE.
REQ-017 OFFER: req_valid SHALL be 1, and req_id SHALL stay stable until the handshake.
REQ-018 OFFER, req_ready=1: clear pending[req_id], set last to req_id, load cnt with HOLDOFF-1 and go to HOLD.
REQ-019 OFFER, req_ready=0: stay in OFFER with no change to req_id.
REQ-020 HOLD: if cnt=0 go to IDLE, else decrement cnt. HOLD therefore lasts exactly HOLDOFF cycles and req_valid=0 throughout.
REQ-021 Pending bits set during OFFER or HOLD SHALL be retained and served after HOLD, with no loss.
REQ-022 If rise[i] coincides with the grant of channel i, set wins: pending[i] ends at 1, the event is re-served later, and dropped[i] is not set.
REQ-023 Latency: if btn[i] is first sampled high at edge k with the FSM in IDLE, pending[i] is 1 after edge k and req_valid is 1 after edge k+1.
REQ-024 Minimum spacing between consecutive grants SHALL be HOLDOFF+2 cycles (handshake edge g, next req_valid after edge g+HOLDOFF+1).
REQ-025 A btn held high SHALL produce exactly one event per 0->1 transition.

Reset
REQ-026 When reset=1 at an edge: state=IDLE, req_valid=0, req_id=0, pending=0, dropped=0, busy=0, prev=0, cnt=0, last=2 (channel 0 highest priority first).
REQ-027 Reset SHALL override every other event in the same cycle, including an in-progress OFFER or HOLD.
REQ-028 A btn already high when reset deasserts SHALL register as one press, because prev resets to 0.

Verification
REQ-029 Single press: btn=001 at edge 5, req_ready=1 -> pending=001 after edge 5, req_valid=1 with req_id=0 after edge 6, handshake at edge 7, pending=000, busy=1 for the 4 HOLD cycles, IDLE after edge 11.
REQ-030 Simultaneous press: btn=111 at one edge, req_ready=1, HOLDOFF=4 -> grants in order 0, 1, 2, each spaced 6 cycles apart, then pending=000.
REQ-031 Round-robin fairness: after channel 1 is granted, pending=101 -> next grant is channel 2, then channel 0.
REQ-032 Backpressure and drop: req_ready=0 while offering ch0, and btn[0] toggles 0->1 again -> req_id stays 0, dropped=001, pending=001; after req_ready=1, one grant and pending=000.
REQ-033 Reset mid-HOLD with pending=110 -> after the reset edge all outputs are 0; the first grant after reset requires a new press.
REQ-034 Held button: btn=010 held for 50 cycles -> exactly one grant for ch1; release, then re-press -> a second grant.
